// File: rtl/vec_player_misr_if.sv
// Load, replay and signature signals between a vector player and its user.
// The master side loads vectors and observes; the slave side is the player.
interface vec_player_misr_if #(
    parameter int IN_W   = 256,
    parameter int OUT_W  = 646,
    parameter int DEPTH  = 32,
    parameter int MISR_W = 32
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic              load_valid;
    logic [IN_W-1:0]   load_data;
    logic              load_ready;
    logic              start;
    logic [IN_W-1:0]   stim;
    logic [OUT_W-1:0]  dut_y;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic [IW-1:0]     vec_idx;
    logic [CW-1:0]     count;
    logic [MISR_W-1:0] signature;

    modport master (
        output load_valid, load_data, start, dut_y,
        input  load_ready, stim, sample_valid, busy, done,
        input  vec_idx, count, signature
    );

    modport slave (
        input  load_valid, load_data, start, dut_y,
        output load_ready, stim, sample_valid, busy, done,
        output vec_idx, count, signature
    );
endinterface

// File: rtl/vec_player_misr.sv
// Replays stored stimulus vectors to a DUT, holding each HOLD cycles,
// and compacts one DUT response per vector into a MISR signature.
module vec_player_misr #(
    parameter int              IN_W   = 256,
    parameter int              OUT_W  = 646,
    parameter int              DEPTH  = 32,
    parameter int              HOLD   = 1,
    parameter int              MISR_W = 32,
    parameter logic [MISR_W-1:0] POLY = MISR_W'(32'h04C11DB7),
    parameter logic [MISR_W-1:0] SEED = '1
) (
    input logic clk,
    input logic rst,
    vec_player_misr_if.slave bus
);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NCH = (OUT_W + MISR_W - 1) / MISR_W;
    localparam int PW  = NCH * MISR_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [IN_W-1:0]   mem [DEPTH];
    logic [HW-1:0]     h;
    logic [HW-1:0]     h_nx;
    logic [IW-1:0]     vec_idx;
    logic [IW-1:0]     idx_nx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    logic [IN_W-1:0]   stim;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic [MISR_W-1:0] sig;
    logic [PW-1:0]     pad;
    logic [MISR_W-1:0] fold;
    logic [MISR_W-1:0] misr_nx;
    logic              load_hs;
    logic              hold_end;
    logic              last;

    assign bus.load_ready   = (state == IDLE) && (count < CW'(DEPTH));
    assign bus.stim         = stim;
    assign bus.sample_valid = sample_valid;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.vec_idx      = vec_idx;
    assign bus.count        = count;
    assign bus.signature    = sig;

    assign load_hs  = bus.load_valid && bus.load_ready;
    assign count_nx = load_hs ? count + 1'b1 : count;
    assign h_nx     = h + 1'b1;
    assign idx_nx   = vec_idx + 1'b1;
    assign hold_end = (h == HW'(HOLD - 1));
    assign last     = ((CW'(vec_idx) + CW'(1)) == count);

    // Zero-padded response folded into one word, chunk 0 at the LSBs.
    always_comb begin
        pad  = PW'(bus.dut_y);
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ pad[i*MISR_W +: MISR_W];
        end
        misr_nx = {sig[MISR_W-2:0], 1'b0}
                ^ (sig[MISR_W-1] ? POLY : '0)
                ^ fold;
    end

    always_ff @(posedge clk) begin
        if (load_hs) begin
            mem[IW'(count)] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            vec_idx      <= '0;
            h            <= '0;
            stim         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sig          <= SEED;
        end else begin
            unique case (state)
                IDLE: begin
                    done  <= 1'b0;
                    count <= count_nx;
                    if (bus.start) begin
                        if (count_nx != '0) begin
                            state        <= RUN;
                            busy         <= 1'b1;
                            vec_idx      <= '0;
                            h            <= '0;
                            sig          <= SEED;
                            sample_valid <= (HOLD == 1);
                            // A same-cycle first load is not in mem yet.
                            stim <= (count == '0) ? bus.load_data
                                                  : mem[0];
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hold_end) begin
                        sig <= misr_nx;
                        if (last) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stim         <= '0;
                            sample_valid <= 1'b0;
                        end else begin
                            vec_idx      <= idx_nx;
                            stim         <= mem[idx_nx];
                            h            <= '0;
                            sample_valid <= (HOLD == 1);
                        end
                    end else begin
                        h            <= h_nx;
                        sample_valid <= (h_nx == HW'(HOLD - 1));
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_player_misr.sv
// Directed bench: a short-vector HOLD=1 player and a wide HOLD=3 player,
// with expected stimulus and signatures queued as vectors are loaded.
module tb_vec_player_misr;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fmode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0]  q1[$];
    logic [255:0] q3[$];

    always #5 clk = ~clk;

    vec_player_misr_if #(.IN_W(32), .OUT_W(32), .DEPTH(4), .MISR_W(32)) b1 ();
    vec_player_misr_if #(.IN_W(256), .OUT_W(646), .DEPTH(4), .MISR_W(32)) b3 ();

    assign b1.dut_y = b1.stim;
    assign b3.dut_y = fmode ? (646'(1) << 645) : 646'(b3.stim);

    vec_player_misr #(
        .IN_W(32), .OUT_W(32), .DEPTH(4), .HOLD(1), .MISR_W(32)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    vec_player_misr #(
        .IN_W(256), .OUT_W(646), .DEPTH(4), .HOLD(3), .MISR_W(32)
    ) u3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );

    function automatic logic [31:0] step(logic [31:0] s, logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [31:0] fold646(logic [645:0] y);
        logic [671:0] p;
        logic [31:0]  r;
        p = 672'(y);
        r = '0;
        for (int i = 0; i < 21; i++) r = r ^ p[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load1(input logic [31:0] v);
        b1.load_valid = 1'b1;
        b1.load_data  = v;
        q1.push_back(v);
        tick();
        b1.load_valid = 1'b0;
    endtask

    task automatic load3(input logic [255:0] v);
        b3.load_valid = 1'b1;
        b3.load_data  = v;
        q3.push_back(v);
        tick();
        b3.load_valid = 1'b0;
    endtask

    function automatic logic [31:0] model1();
        logic [31:0] s;
        s = SEED;
        foreach (q1[i]) s = step(s, q1[i]);
        return s;
    endfunction

    function automatic logic [31:0] model3();
        logic [31:0] s;
        s = SEED;
        foreach (q3[i]) s = step(s, fold646(fmode ? (646'(1) << 645) : 646'(q3[i])));
        return s;
    endfunction

    task automatic pulse_start1();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
    endtask

    task automatic pulse_start3();
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
    endtask

    task automatic run1(input int n, input logic [31:0] exp);
        int cyc = 0, smp = 0, bsy = 0;
        logic last_sv = 1'b0;
        while (b1.done !== 1'b1 && cyc < 64) begin
            if (b1.busy === 1'b1) bsy++;
            last_sv = b1.sample_valid;
            if (b1.sample_valid === 1'b1) begin
                smp++;
                if (q1.size() > 0) chk("stim1", 256'(b1.stim), 256'(q1.pop_front()));
            end
            tick();
            cyc++;
        end
        chk("done1", 256'(b1.done), 256'(1));
        chk("done_after_sample1", 256'(last_sv), 256'(1));
        chk("busy_cycles1", 256'(bsy), 256'(n));
        chk("samples1", 256'(smp), 256'(n));
        chk("sig1", 256'(b1.signature), 256'(exp));
        chk("stim_done1", 256'(b1.stim), 256'(0));
        tick();
        chk("done_pulse1", 256'(b1.done), 256'(0));
    endtask

    task automatic run3(input int n, input logic [31:0] exp);
        int cyc = 0, smp = 0, bsy = 0;
        while (b3.done !== 1'b1 && cyc < 64) begin
            if (b3.busy === 1'b1) bsy++;
            chk("sv3", 256'(b3.sample_valid), 256'(cyc % 3 == 2));
            if (q3.size() > 0) chk("stim3", b3.stim, q3[0]);
            if (b3.sample_valid === 1'b1) begin
                smp++;
                if (q3.size() > 0) void'(q3.pop_front());
            end
            tick();
            cyc++;
        end
        chk("done3", 256'(b3.done), 256'(1));
        chk("busy_cycles3", 256'(bsy), 256'(3 * n));
        chk("samples3", 256'(smp), 256'(n));
        chk("sig3", 256'(b3.signature), 256'(exp));
        tick();
        chk("done_pulse3", 256'(b3.done), 256'(0));
    endtask

    initial begin
        logic [31:0] e;
        b1.load_valid = 1'b0; b1.load_data = '0; b1.start = 1'b0;
        b3.load_valid = 1'b0; b3.load_data = '0; b3.start = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_sig", 256'(b1.signature), 256'(SEED));
        chk("rst_count", 256'(b1.count), 256'(0));
        chk("rst_ready", 256'(b1.load_ready), 256'(1));
        chk("rst_stim", 256'(b1.stim), 256'(0));
        chk("rst_busy", 256'(b1.busy), 256'(0));
        chk("rst_done", 256'(b1.done), 256'(0));

        pulse_start3();
        chk("empty_done", 256'(b3.done), 256'(1));
        chk("empty_busy", 256'(b3.busy), 256'(0));
        chk("empty_sig", 256'(b3.signature), 256'(SEED));
        tick();
        chk("empty_done_end", 256'(b3.done), 256'(0));
        chk("empty_busy_end", 256'(b3.busy), 256'(0));

        // Push 1..6 back to back; only the first four fit.
        b1.load_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b1.load_data = 32'(i);
            if (i <= 4) q1.push_back(32'(i));
            tick();
            chk("fill_count", 256'(b1.count), 256'(i < 4 ? i : 4));
            chk("fill_ready", 256'(b1.load_ready), 256'(i < 4));
        end
        b1.load_valid = 1'b0;

        e = model1();
        pulse_start1();
        run1(4, e);

        // Restart without reload: same vectors, same signature.
        for (int i = 1; i <= 4; i++) q1.push_back(32'(i));
        pulse_start1();
        run1(4, e);
        chk("retain_count", 256'(b1.count), 256'(4));

        load3(rnd256());
        load3(rnd256());
        e = model3();
        pulse_start3();
        run3(2, e);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        q3.delete();
        fmode = 1'b1;
        load3(rnd256());
        e = model3();
        chk("fold_model", 256'(e), 256'(32'hFB3EE269));
        pulse_start3();
        run3(1, 32'hFB3EE269);
        fmode = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        q1.delete();
        load1(32'h1);
        load1(32'h2);
        load1(32'h3);
        pulse_start1();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 256'(b1.busy), 256'(0));
        chk("abort_count", 256'(b1.count), 256'(0));
        chk("abort_stim", 256'(b1.stim), 256'(0));
        chk("abort_sv", 256'(b1.sample_valid), 256'(0));
        chk("abort_sig", 256'(b1.signature), 256'(SEED));
        q1.delete();
        load1(32'h1);
        load1(32'h2);
        load1(32'h3);
        e = model1();
        pulse_start1();
        run1(3, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_player_misr.md
Name: vec_player_misr

Overview:
- Parametrised on-chip stimulus player and response compactor for equivalence runs of generated designs.
- Stores up to DEPTH input vectors and replays them to a DUT, holding each vector for HOLD clock cycles.
- Samples the DUT output bus once per vector and folds it into a MISR signature.
- Replaces per-cycle textual output dumps: synthesized and behavioural runs are compared by one signature word.

Parameters:
IN_W, 256, width of one stimulus vector (concatenated DUT inputs)
OUT_W, 646, width of DUT output bus
DEPTH, 32, vector memory entries (power of two not required)
HOLD, 1, clock cycles each vector is applied (>=1)
MISR_W, 32, signature width
POLY, 32'h04C11DB7, MISR feedback polynomial (MISR_W bits)
SEED, all-ones, MISR value after start

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
load_valid  in  1  load_data holds a vector to store
load_data  in  IN_W  vector to append to memory
load_ready  out  1  memory can accept a vector
start  in  1  begin replay of stored vectors
stim  out  IN_W  vector driven to DUT
dut_y  in  OUT_W  DUT response
sample_valid  out  1  dut_y is being compacted this cycle
busy  out  1  replay in progress
done  out  1  one-cycle pulse at end of replay
vec_idx  out  clog2(DEPTH)  index of vector on stim
count  out  clog2(DEPTH+1)  number of stored vectors
signature  out  MISR_W  current MISR value

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; count=0; vec_idx=0; stim=0.
  - busy=0; done=0; sample_valid=0; signature=SEED.
  - Memory contents don't-care.
  - Reset mid-RUN aborts immediately. The next cycle shows the reset values.
- States: IDLE, RUN, DONE.
- IDLE:
  - load_ready = (count<DEPTH).
  - Load handshake on load_valid&&load_ready: mem[count] <= load_data; count++.
  - load_valid while full is ignored; count stays DEPTH.
  - start && count>0 -> RUN:
    - vec_idx=0, hold counter=0, signature<=SEED.
    - stim<=mem[0], visible the cycle after start.
  - start with count==0: no transition; done pulses 1 cycle; signature unchanged.
  - start and a load handshake in the same cycle: the load completes first and count includes it. The replay covers the new vector.
  - stim=0 in IDLE.
- RUN:
  - load_ready=0; busy=1; start ignored.
  - stim=mem[vec_idx] registered, stable for HOLD cycles.
  - Hold counter h counts 0..HOLD-1.
  - On the cycle h==HOLD-1, sample_valid=1 and the posedge ending that cycle updates:
    - signature <= {signature[MISR_W-2:0],1'b0} ^ (signature[MISR_W-1] ? POLY : 0) ^ fold(dut_y)
    - fold: zero-pad dut_y to a multiple of MISR_W; XOR all MISR_W-bit chunks. Chunk 0 = bits [MISR_W-1:0].
  - After sampling: if vec_idx==count-1 -> DONE; else vec_idx++, h=0.
  - dut_y is treated as combinational from stim. With HOLD>=2 the DUT gets HOLD-1 settle/register cycles before the sample.
- DONE:
  - Lasts one cycle: done=1, busy=0, stim=0; then IDLE.
  - signature and count are retained. A new start replays the same vectors with a fresh seed.
- Clearing memory requires rst. No partial overwrite.
- Latency: total RUN cycles = count*HOLD; done asserts exactly 1 cycle after the last sample.
- No X propagation: an X on dut_y corrupts the signature. The bench must ensure dut_y is known at sample cycles.

Test Plan:
- Reset/idle:
  - Stimulus: rst high 2 cycles then low.
  - Required: signature=32'hFFFFFFFF, count=0, load_ready=1, stim=0, busy=0.
- Fill and overflow:
  - Stimulus: DEPTH=4; push 6 vectors 1..6 with load_valid held.
  - Required: count=4, load_ready=0 after the 4th, mem holds 1..4, pushes 5 and 6 dropped.
- Replay, HOLD=1, OUT_W=32, dut_y=stim[31:0] loopback, vectors 1,2,3:
  - Required: stim sequence 1,2,3 on consecutive cycles; sample_valid high 3 cycles.
  - Required: done one cycle later; signature equals the software MISR from SEED over 1,2,3.
- HOLD=3:
  - Stimulus: 2 vectors.
  - Required: each stim stable 3 cycles; sample_valid only on the 3rd; busy for 6 cycles.
- Fold width:
  - Stimulus: OUT_W=646, dut_y with only bit 645 set, one vector.
  - Required: signature = step(SEED) ^ (1<<(645 mod 32)) = step(SEED) ^ 32'h00000020.
- Abort and restart:
  - Stimulus: rst asserted mid-RUN.
  - Required: next cycle busy=0, count=0, stim=0.
  - Stimulus: reload and restart.
  - Required: signature identical to a clean run.
- Empty start:
  - Stimulus: start with count=0.
  - Required: single done pulse, busy never asserted.
